// File: rtl/cnn_pe_pkg.sv
// Shared types and constants for the CNN processing-element datapath.
// Reduction stages share the window FSM encoding and W-bit saturation limits.
package cnn_pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int PE_W = 16;
  localparam logic [PE_W-1:0] PE_SMAX = {1'b0, {(PE_W-1){1'b1}}};
  localparam logic [PE_W-1:0] PE_SMIN = {1'b1, {(PE_W-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// Narrows a wide signed value to W bits, clamping to the signed range.
// Purely combinational; sat flags that a clamp happened.
module sat_narrow #(
  parameter int W  = 16,
  parameter int AW = 24
) (
  input  logic signed [AW-1:0] din,
  output logic        [W-1:0]  dout,
  output logic                 sat
);

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // Fits in W bits iff all bits from W-1 upward equal the sign
  logic [AW-W:0] top;
  assign top = din[AW-1:W-1];

  always_comb begin
    dout = din[W-1:0];
    sat  = 1'b0;
    if ((top != '0) && (top != '1)) begin
      sat  = 1'b1;
      dout = din[AW-1] ? SMIN : SMAX;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a window of signed products and emits one saturated result per window.
// Valid/ready on both sides; back-to-back windows run at one beat per cycle.
module product_accumulator
  import cnn_pe_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_sat
);

  localparam int ACC_W = W + CNT_W;

  acc_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [CNT_W-1:0]  len_q, len_d;
  logic                     ov_q, ov_d;
  logic        [W-1:0]      od_q, od_d;
  logic                     os_q, os_d;

  logic                     take;
  logic                     start;
  logic                     last;
  logic signed [ACC_W-1:0]  ext;
  logic signed [ACC_W-1:0]  sum;
  logic        [CNT_W-1:0]  len_eff;
  logic        [CNT_W-1:0]  cnt_inc;
  logic        [W-1:0]      nar_d;
  logic                     nar_s;

  assign in_ready = (state_q != HOLD) | out_ready;
  assign take     = in_valid & in_ready & ~clr;

  // Any beat outside ACCUM opens a fresh window
  assign start   = (state_q != ACCUM);
  assign ext     = {{CNT_W{in_data[W-1]}}, in_data};
  assign sum     = start ? ext : acc_q + ext;
  assign len_eff = !start ? len_q :
                   (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign cnt_inc = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign last    = (cnt_inc == len_eff);

  sat_narrow #(
    .W  (W),
    .AW (ACC_W)
  ) u_sat (
    .din  (sum),
    .dout (nar_d),
    .sat  (nar_s)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ov_d    = ov_q;
    od_d    = od_q;
    os_d    = os_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      if ((state_q == HOLD) && out_ready) begin
        state_d = IDLE;
        ov_d    = 1'b0;
      end
      if (take) begin
        acc_d = sum;
        cnt_d = cnt_inc;
        len_d = len_eff;
        if (last) begin
          state_d = HOLD;
          ov_d    = 1'b1;
          od_d    = nar_d;
          os_d    = nar_s;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= CNT_W'(1);
      ov_q    <= 1'b0;
      od_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      os_q    <= os_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sat   = os_q;

endmodule
